// File: rtl/sdram_pkg.sv
// Shared types and sizes for the SDRAM slot arbiter and its phase sequencer.
package sdram_pkg;
    localparam int SLOT_PHASES = 8;
    localparam int PH_W        = $clog2(SLOT_PHASES);
    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_A,
        GNT_B
    } gnt_t;
endpackage

// File: rtl/sdram_slot_phase.sv
// Slot phase counter: splits clk into 8-clock slots and produces clkref,
// the arbitration strobe and the read-capture strobe.
module sdram_slot_phase
    import sdram_pkg::*;
#(
    parameter int READ_PHASE = 6
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PH_W-1:0] ph,
    output logic            clkref,
    output logic            slot_start,
    output logic            capture
);
    logic [PH_W-1:0] ph_next;

    assign ph_next = ph + 1'b1;

    // clkref is registered from ph_next so it is high exactly while ph is 0..3
    always_ff @(posedge clk) begin
        if (reset) begin
            ph     <= '0;
            clkref <= 1'b0;
        end else begin
            ph     <= ph_next;
            clkref <= ~ph_next[PH_W-1];
        end
    end

    assign slot_start = (ph == PH_W'(SLOT_PHASES - 1));
    assign capture    = (ph == PH_W'(READ_PHASE));
endmodule

// File: rtl/sdram_slot_arbiter.sv
// Two-port slot arbiter in front of the 8-bit SDRAM controller: grants each
// 8-clock slot to port A, port B or an idle (refresh) slot.
module sdram_slot_arbiter
    import sdram_pkg::*;
#(
    parameter int READ_PHASE       = 6,
    parameter int REFRESH_INTERVAL = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ack,
    output logic              clkref,
    output logic              sd_oe,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_din,
    input  logic [DATA_W-1:0] sd_dout
);
    localparam logic [CNT_W-1:0] REF_MAX = CNT_W'(REFRESH_INTERVAL);

    logic [PH_W-1:0]   ph;
    logic              slot_start;
    logic              capture;
    gnt_t              gnt;
    gnt_t              done;
    gnt_t              win;
    logic              last_a;
    logic [CNT_W-1:0]  grant_cnt;
    logic              a_ok;
    logic              b_ok;
    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_din;

    sdram_slot_phase #(
        .READ_PHASE(READ_PHASE)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .ph        (ph),
        .clkref    (clkref),
        .slot_start(slot_start),
        .capture   (capture)
    );

    // Slot owner register; done remembers who owned the slot just finished
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= GNT_IDLE;
            done      <= GNT_IDLE;
            last_a    <= 1'b0;
            grant_cnt <= '0;
        end else if (slot_start) begin
            gnt  <= win;
            done <= gnt;
            if (win == GNT_IDLE) begin
                grant_cnt <= '0;
            end else begin
                grant_cnt <= grant_cnt + 1'b1;
                last_a    <= (win == GNT_A);
            end
        end
    end

    // A port still holding the slot it owns now is showing its old request
    always_comb begin
        a_ok = a_req && (gnt != GNT_A) && !a_ack;
        b_ok = b_req && (gnt != GNT_B) && !b_ack;
        win  = GNT_IDLE;
        if (grant_cnt != REF_MAX) begin
            if (a_ok && b_ok) begin
                win = last_a ? GNT_B : GNT_A;
            end else if (a_ok) begin
                win = GNT_A;
            end else if (b_ok) begin
                win = GNT_B;
            end
        end
    end

    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = sd_addr;
        nxt_din  = sd_din;
        unique case (win)
            GNT_A: begin
                nxt_we   = a_we;
                nxt_addr = a_addr;
                nxt_din  = a_din;
            end
            GNT_B: begin
                nxt_we   = b_we;
                nxt_addr = b_addr;
                nxt_din  = b_din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sd_oe   <= 1'b0;
            sd_we   <= 1'b0;
            sd_addr <= '0;
            sd_din  <= '0;
        end else if (slot_start) begin
            if (win == GNT_IDLE) begin
                sd_oe <= 1'b0;
                sd_we <= 1'b0;
            end else begin
                sd_oe   <= ~nxt_we;
                sd_we   <= nxt_we;
                sd_addr <= nxt_addr;
                sd_din  <= nxt_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout <= '0;
            b_dout <= '0;
        end else if (capture && sd_oe) begin
            if (gnt == GNT_A) a_dout <= sd_dout;
            if (gnt == GNT_B) b_dout <= sd_dout;
        end
    end

    assign a_ack = (ph == '0) && (done == GNT_A);
    assign b_ack = (ph == '0) && (done == GNT_B);
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: read/write, contention,
// forced refresh, reset mid-slot and phase alignment.
module tb_sdram_slot_arbiter;
    import sdram_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_din = '0, b_din = '0;
    logic [DATA_W-1:0] a_dout, b_dout, sd_din, sd_dout;
    logic              a_ack, b_ack, clkref, sd_oe, sd_we;
    logic [ADDR_W-1:0] sd_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [2:0] tb_ph = '0;

    sdram_slot_arbiter #(
        .READ_PHASE      (6),
        .REFRESH_INTERVAL(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_req  (a_req),
        .a_we   (a_we),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_dout (a_dout),
        .a_ack  (a_ack),
        .b_req  (b_req),
        .b_we   (b_we),
        .b_addr (b_addr),
        .b_din  (b_din),
        .b_dout (b_dout),
        .b_ack  (b_ack),
        .clkref (clkref),
        .sd_oe  (sd_oe),
        .sd_we  (sd_we),
        .sd_addr(sd_addr),
        .sd_din (sd_din),
        .sd_dout(sd_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tb_ph <= '0;
        else tb_ph <= tb_ph + 3'd1;
    end

    function automatic logic [7:0] model(input logic [ADDR_W-1:0] ad);
        if (ad == 25'h0001234) return 8'h5A;
        return ad[7:0] ^ ad[15:8] ^ 8'h3C;
    endfunction

    // Controller data is only valid during the capture phase
    assign sd_dout = (sd_oe && tb_ph == 3'd6) ? model(sd_addr) : 8'hEE;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;

    logic        pa = 0, pb = 0;
    logic [34:0] psd = '0;
    bit          log_en = 0;
    int          slog[$];
    int          acks[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (a_ack) begin
                chk("a_ack_ph", tb_ph, 0);
                chk("a_ack_pulse", pa, 0);
                if (qa.size() == 0) chk("a_ack_spurious", 1, 0);
                else chk("a_dout", a_dout, qa.pop_front());
                if (log_en) acks.push_back(cyc);
            end
            if (b_ack) begin
                chk("b_ack_ph", tb_ph, 0);
                chk("b_ack_pulse", pb, 0);
                if (qb.size() == 0) chk("b_ack_spurious", 1, 0);
                else chk("b_dout", b_dout, qb.pop_front());
                if (log_en) acks.push_back(cyc);
            end
            if (tb_ph != 3'd0)
                chk("sd_hold", {sd_oe, sd_we, sd_addr, sd_din}, psd);
            if (tb_ph == 3'd0 && log_en)
                slog.push_back((sd_oe | sd_we) ? (sd_addr[24] ? 2 : 1) : 0);
        end
        pa  = a_ack;
        pb  = b_ack;
        psd = {sd_oe, sd_we, sd_addr, sd_din};
    end

    task automatic xfer(input bit port, input bit we,
                        input logic [ADDR_W-1:0] ad,
                        input logic [7:0] din, input bit keep);
        int    n;
        logic  got;
        string t;
        t = port ? "b_ack_seen" : "a_ack_seen";
        if (!port) begin
            a_req = 1; a_we = we; a_addr = ad; a_din = din;
            if (!we) last_a = model(ad);
            qa.push_back(last_a);
        end else begin
            b_req = 1; b_we = we; b_addr = ad; b_din = din;
            if (!we) last_b = model(ad);
            qb.push_back(last_b);
        end
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = port ? b_ack : a_ack;
        end
        chk(t, got, 1);
        if (!keep) begin
            if (!port) a_req = 0;
            else b_req = 0;
        end
    endtask

    int n_oe, n_we, n_wm, n_aa, n_ba;

    task automatic observe(input int n);
        n_oe = 0; n_we = 0; n_wm = 0; n_aa = 0; n_ba = 0;
        repeat (n) begin
            @(negedge clk);
            n_oe += int'(sd_oe);
            n_we += int'(sd_we);
            n_aa += int'(a_ack);
            n_ba += int'(b_ack);
            if (sd_we && sd_din == 8'hC3 && sd_addr == 25'h1FFFFFF) n_wm++;
        end
    endtask

    task automatic chk_reset_state(input string p);
        chk({p, "_clkref"}, clkref, 0);
        chk({p, "_sd_oe"}, sd_oe, 0);
        chk({p, "_sd_we"}, sd_we, 0);
        chk({p, "_sd_addr"}, sd_addr, 0);
        chk({p, "_sd_din"}, sd_din, 0);
        chk({p, "_a_dout"}, a_dout, 0);
        chk({p, "_b_dout"}, b_dout, 0);
        chk({p, "_a_ack"}, a_ack, 0);
        chk({p, "_b_ack"}, b_ack, 0);
    endtask

    int exp_log[9] = '{1, 2, 1, 2, 0, 1, 2, 1, 2};
    int exp_gap[7] = '{8, 8, 8, 16, 8, 8, 8};

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        reset = 0;

        fork
            xfer(0, 0, 25'h0001234, 8'h00, 0);
            observe(40);
        join
        chk("rd_oe_cycles", n_oe, 8);
        chk("rd_we_cycles", n_we, 0);
        chk("rd_a_acks", n_aa, 1);
        chk("rd_b_acks", n_ba, 0);
        chk("rd_a_dout", a_dout, 8'h5A);

        fork
            xfer(1, 1, 25'h1FFFFFF, 8'hC3, 0);
            observe(40);
        join
        chk("wr_we_cycles", n_we, 8);
        chk("wr_we_match", n_wm, 8);
        chk("wr_oe_cycles", n_oe, 0);
        chk("wr_b_dout", b_dout, 0);
        chk("wr_a_dout", a_dout, 8'h5A);

        acks.delete();
        slog.delete();
        log_en = 1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    xfer(0, 0, 25'(32'h10 * (i + 1)), 8'h00, i < 3);
            end
            begin
                xfer(1, 0, 25'h1000100, 8'h00, 1);
                xfer(1, 0, 25'h1000200, 8'h00, 1);
                xfer(1, 1, 25'h1000300, 8'h77, 1);
                xfer(1, 0, 25'h1000400, 8'h00, 0);
            end
        join
        repeat (2) @(negedge clk);
        log_en = 0;
        while (slog.size() > 0 && slog[0] == 0) void'(slog.pop_front());
        while (slog.size() > 0 && slog[slog.size() - 1] == 0)
            void'(slog.pop_back());
        chk("cont_log_len", slog.size(), 9);
        for (int i = 0; i < 9 && i < slog.size(); i++)
            chk($sformatf("cont_slot%0d", i), slog[i], exp_log[i]);
        chk("cont_ack_cnt", acks.size(), 8);
        for (int i = 0; i < 7 && i + 1 < acks.size(); i++)
            chk($sformatf("cont_gap%0d", i), acks[i + 1] - acks[i], exp_gap[i]);

        a_we = 0;
        a_addr = 25'h0000777;
        a_req = 1;
        n = 0;
        while (!(sd_oe && tb_ph == 3'd3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_ph3", sd_oe && tb_ph == 3'd3, 1);
        reset = 1;
        a_req = 0;
        @(negedge clk);
        chk("mid_oe_drop", sd_oe, 0);
        chk("mid_we_drop", sd_we, 0);
        @(negedge clk);
        chk_reset_state("mid");
        reset = 0;
        last_a = '0;
        last_b = '0;
        observe(24);
        chk("mid_no_a_ack", n_aa, 0);
        chk("mid_no_b_ack", n_ba, 0);

        fork
            begin
                xfer(1, 0, 25'h1000500, 8'h00, 1);
                xfer(1, 1, 25'h1000600, 8'h11, 0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    chk("clkref", clkref, tb_ph < 3'd4);
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
